// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared definitions for the lab-2 calculator: instruction
//                opcodes, UART receiver state encoding, default clock/baud.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

  // Instruction opcodes carried in inst_wd[7:6]
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  // Default system clock and serial line rate
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 1_000_000;

  // Receiver frame state; PARITY is only visited in the 8E1 build
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line.
//                Both flops preset to 1 (line idle level) on reset.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_s
);

  logic meta_q;
  logic rx_s_q;

  // Two-stage resynchronisation into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= rx_async;
      rx_s_q <= meta_q;
    end
  end

  assign rx_s = rx_s_q;

endmodule
`default_nettype wire

// File: rtl/uart_inst_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_inst_rx
//  Description : UART receiver (8N1, LSB first) delivering calculator
//                instruction bytes over a ready/valid handshake.
//                Optional macro UART_RX_PARITY_EN: 8E1 framing with a
//                parity_err pulse output; bad-parity bytes are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_inst_rx
  import calc_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RsRx,
  input  logic       inst_rdy,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_async (RsRx),
    .rx_s     (rx_s)
  );

  rx_state_t     state_q,  state_d;
  logic [CW-1:0] baud_q,   baud_d;
  logic [2:0]    bit_q,    bit_d;
  logic [7:0]    shift_q,  shift_d;
  logic [7:0]    wd_q,     wd_d;
  logic          vld_q,    vld_d;
  logic          ferr_q,   ferr_d;
  logic          ovr_q,    ovr_d;
  // settle_q counts clocks since reset until the synchronizer output is real;
  // armed_q blocks start detection until the line has been seen high, so a
  // frame cut by reset is not mistaken for a new start bit.
  logic [1:0]    settle_q, settle_d;
  logic          armed_q,  armed_d;
`ifdef UART_RX_PARITY_EN
  logic          perr_q,   perr_d;
  logic          pbad_q,   pbad_d;
`endif
  logic          deliver;

  // Frame sequencing, shift register and output handshake
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wd_d     = wd_q;
    vld_d    = vld_q;
    ferr_d   = 1'b0;
    ovr_d    = ovr_q;
    settle_d = (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & rx_s);
`ifdef UART_RX_PARITY_EN
    perr_d   = 1'b0;
    pbad_d   = pbad_q;
`endif
    deliver  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (armed_q && !rx_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (baud_q == C_HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + C_ONE;
        end
      end
      RX_DATA: begin
        if (baud_q == C_FULL_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + C_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (baud_q == C_FULL_LAST) begin
          baud_d  = '0;
          pbad_d  = (^shift_q) != rx_s;
          perr_d  = (^shift_q) != rx_s;
          state_d = RX_STOP;
        end else begin
          baud_d = baud_q + C_ONE;
        end
      end
`endif
      RX_STOP: begin
        if (baud_q == C_FULL_LAST) begin
          baud_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            deliver = !pbad_q;
`else
            deliver = 1'b1;
`endif
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          baud_d = baud_q + C_ONE;
        end
      end
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    // A completed byte replaces the held one only if the slot is free or
    // being consumed this same cycle; otherwise it is lost and flagged.
    if (deliver) begin
      if (!vld_q || inst_rdy) begin
        wd_d  = shift_q;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && inst_rdy) begin
      vld_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      wd_q     <= 8'h00;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      pbad_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wd_q     <= wd_d;
      vld_q    <= vld_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
      pbad_q   <= pbad_d;
`endif
    end
  end

  assign inst_wd   = wd_q;
  assign inst_vld  = vld_q;
  assign busy      = (state_q != RX_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_inst_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_inst_rx
//  Description : Directed self-checking bench for uart_inst_rx at 100 clk/bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_inst_rx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RsRx = 1'b1;
  logic       inst_rdy = 1'b0;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Monitor counters, written only by the monitor process
  int cyc = 0;
  int vld_hi = 0;
  int vld_rises = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic vld_prev = 1'b0;

  uart_inst_rx #(.CLK_FREQ(100_000_000), .BAUD(1_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .RsRx      (RsRx),
    .inst_rdy  (inst_rdy),
    .inst_wd   (inst_wd),
    .inst_vld  (inst_vld),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Count edges and observe outputs shortly after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (inst_vld) vld_hi = vld_hi + 1;
    if (inst_vld && !vld_prev) begin
      vld_rises = vld_rises + 1;
      rise_cyc  = cyc;
    end
    vld_prev = inst_vld;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt = perr_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RsRx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(~(^d));
    drive_bit(1'b1);
  endtask
`endif

  int t0;
  int r0;
  int h0;
  int f0;
  int p0;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_wd",   {24'd0, inst_wd}, 32'h00);
    check("rst_vld",  {31'd0, inst_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr",  {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: PUSH r1,3 with consumer ready
    inst_rdy = 1'b1;
    h0 = vld_hi; f0 = ferr_cnt;
    t0 = cyc;
    send_frame(8'h13, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_wd", {24'd0, inst_wd}, 32'h13);
    check("t1_vld_cycles", vld_hi - h0, 32'd1);
    check("t1_latency_window", {31'd0, ((rise_cyc - t0) >= 945) && ((rise_cyc - t0) <= 960)}, 32'd1);
    check("t1_ferr", ferr_cnt - f0, 32'd0);

    // 2: back-to-back frames while consumer stalls
    inst_rdy = 1'b0;
    r0 = vld_rises;
    send_frame(8'h5B, 1'b1);
    check("t2_first_vld", {31'd0, inst_vld}, 32'd1);
    check("t2_first_wd",  {24'd0, inst_wd}, 32'h5B);
    check("t2_first_ovr", {31'd0, overrun}, 32'd0);
    send_frame(8'hC0, 1'b1);
    check("t2_hold_wd",  {24'd0, inst_wd}, 32'h5B);
    check("t2_hold_vld", {31'd0, inst_vld}, 32'd1);
    check("t2_ovr",      {31'd0, overrun}, 32'd1);
    check("t2_rises",    vld_rises - r0, 32'd1);
    inst_rdy = 1'b1;
    @(negedge clk);
    check("t2_accept_vld", {31'd0, inst_vld}, 32'd0);
    repeat (3) @(negedge clk);
    check("t2_accept_wd", {24'd0, inst_wd}, 32'h5B);
    check("t2_ovr_sticky", {31'd0, overrun}, 32'd1);

    // 3: 30-clock glitch on the idle line
    r0 = vld_rises; f0 = ferr_cnt;
    RsRx = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_busy_during", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    RsRx = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_busy_after", {31'd0, busy}, 32'd0);
    check("t3_rises", vld_rises - r0, 32'd0);
    check("t3_ferr", ferr_cnt - f0, 32'd0);

    // 4: low stop bit followed by a long break
    r0 = vld_rises; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (1900) @(negedge clk);
    check("t4_ferr_once", ferr_cnt - f0, 32'd1);
    check("t4_busy_break", {31'd0, busy}, 32'd1);
    check("t4_no_vld", vld_rises - r0, 32'd0);
    RsRx = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h80, 1'b1);
    repeat (5) @(negedge clk);
    check("t4_next_wd", {24'd0, inst_wd}, 32'h80);
    check("t4_next_rise", vld_rises - r0, 32'd1);

    // 5: reset in the middle of a 0xFF frame
    r0 = vld_rises;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_wd",   {24'd0, inst_wd}, 32'h00);
    check("t5_vld",  {31'd0, inst_vld}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ferr", {31'd0, frame_err}, 32'd0);
    check("t5_ovr",  {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (7 * CPB) @(negedge clk);
    check("t5_no_vld", vld_rises - r0, 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h42, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_next_wd", {24'd0, inst_wd}, 32'h42);
    check("t5_next_rise", vld_rises - r0, 32'd1);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch drops the byte, good parity delivers it
    r0 = vld_rises; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame_badpar(8'h07);
    repeat (5) @(negedge clk);
    check("t6_perr", perr_cnt - p0, 32'd1);
    check("t6_drop", vld_rises - r0, 32'd0);
    check("t6_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h07, 1'b1);
    repeat (5) @(negedge clk);
    check("t6_wd", {24'd0, inst_wd}, 32'h07);
    check("t6_rise", vld_rises - r0, 32'd1);
    check("t6_perr_clean", perr_cnt - p0, 32'd1);
`else
    p0 = perr_cnt;
    check("no_parity_pulses", p0, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
